control_sequencer: RTL and testbench

- Multi-cycle instruction sequencer that walks each instruction through fetch, decode, execute, memory and writeback stages.
- Produces the raw 16-bit datapath enable vector and the 4-bit condition field.
- Sits directly upstream of the condition/flags enable gate, which passes or zeroes the vector per NZCV; outputs feed that gate combinationally.
- Also owns memory-wait handling, stall, halt and a memory-timeout error.

---
 rtl/control_sequencer.sv | 175 +++++++++++++++++
 tb/tb_control_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer producing the raw datapath enable
// vector and condition field; optional retired-instruction counter under INSTR_COUNT_EN.
module control_sequencer #(
  parameter int unsigned INSTR_W  = 24,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               mem_ready,
  input  logic               stall,
  output logic [3:0]         condition,
  output logic [15:0]        en_intermediate,
  output logic [2:0]         stage,
  output logic               halted,
  output logic               mem_error
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]        instr_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [15:0] IR_LOAD    = 16'h0001;
  localparam logic [15:0] PC_LOAD    = 16'h0002;
  localparam logic [15:0] PC_INC     = 16'h0004;
  localparam logic [15:0] RF_WRITE   = 16'h0008;
  localparam logic [15:0] RA_LOAD    = 16'h0010;
  localparam logic [15:0] RB_LOAD    = 16'h0020;
  localparam logic [15:0] RZ_LOAD    = 16'h0040;
  localparam logic [15:0] RY_LOAD    = 16'h0080;
  localparam logic [15:0] MEM_READ   = 16'h0100;
  localparam logic [15:0] MEM_WRITE  = 16'h0200;
  localparam logic [15:0] FLAGS_LOAD = 16'h0400;
  localparam logic [15:0] MAR_LOAD   = 16'h0800;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_ALU    = 4'd1;
  localparam logic [3:0] OP_LOAD   = 4'd2;
  localparam logic [3:0] OP_STORE  = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_HALT   = 4'd15;

  localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  state_t           state, next_state;
  logic [8:0]       ir;            // cond, opcode and S bit only
  logic [CNT_W-1:0] wait_cnt;
  logic [15:0]      en_raw;
  logic             mem_wait;
  logic             timeout;
  logic             stall_eff;
  logic             unused_operands;

  wire [3:0] ir_cond   = ir[8:5];
  wire [3:0] ir_opcode = ir[4:1];
  wire       ir_s      = ir[0];

  assign unused_operands = ^instr_in[INSTR_W-10:0];
  assign stall_eff       = stall && (state != S_HALT);

  always_comb begin
    next_state = state;
    en_raw     = '0;
    mem_wait   = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_FETCH: begin
        en_raw = MAR_LOAD | MEM_READ;
        if (mem_ready) begin
          en_raw     = en_raw | IR_LOAD | PC_INC;
          next_state = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        en_raw = RA_LOAD | RB_LOAD;
        case (ir_opcode)
          OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH: next_state = S_EXEC;
          OP_HALT:                              next_state = S_HALT;
          default:                              next_state = S_FETCH;
        endcase
      end
      S_EXEC: begin
        case (ir_opcode)
          OP_ALU: begin
            en_raw     = ir_s ? (RZ_LOAD | FLAGS_LOAD) : RZ_LOAD;
            next_state = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            en_raw     = RZ_LOAD | MAR_LOAD;
            next_state = S_MEM;
          end
          OP_BRANCH: begin
            en_raw     = PC_LOAD;
            next_state = S_FETCH;
          end
          default: next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (ir_opcode == OP_LOAD)
          en_raw = mem_ready ? (MEM_READ | RY_LOAD) : MEM_READ;
        else
          en_raw = MEM_WRITE;
        if (mem_ready)
          next_state = (ir_opcode == OP_LOAD) ? S_WB : S_FETCH;
        else
          mem_wait = 1'b1;
      end
      S_WB: begin
        en_raw     = (ir_opcode == OP_ALU) ? (RF_WRITE | RY_LOAD) : RF_WRITE;
        next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
    // Timeout fires on the wait cycle that would bring the counter up to WAIT_MAX.
    if (mem_wait && (WAIT_MAX != 0) && ((32'(wait_cnt) + 32'd1) == WAIT_MAX)) begin
      next_state = S_HALT;
      timeout    = 1'b1;
    end
    if (stall_eff) begin
      next_state = state;
      en_raw     = '0;
      timeout    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      ir        <= '0;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      state <= next_state;
      if (!stall_eff && (state == S_FETCH) && mem_ready)
        ir <= instr_in[INSTR_W-1 -: 9];
      if (!stall_eff) begin
        if (mem_wait && (next_state == state))
          wait_cnt <= wait_cnt + CNT_W'(1);
        else
          wait_cnt <= '0;
      end
      if (timeout)
        mem_error <= 1'b1;
    end
  end

`ifdef INSTR_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      instr_count <= '0;
    else if ((state != S_FETCH) && (state != S_HALT) && (next_state == S_FETCH))
      instr_count <= instr_count + 32'd1;
  end
`endif

  assign stage           = state;
  assign halted          = !reset && (state == S_HALT);
  assign en_intermediate = reset ? '0 : en_raw;
  assign condition       = (reset || state == S_FETCH || state == S_DECODE || state == S_HALT)
                           ? 4'h0 : ir_cond;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expectations are queued as
// stimulus is applied and compared against stage/en/condition/halted at the negedge.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] instr_in;
  logic        mem_ready;
  logic        stall;
  logic [3:0]  condition;
  logic [15:0] en_intermediate;
  logic [2:0]  stage;
  logic        halted;
  logic        mem_error;
`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        mr;
    logic        st;
    logic [2:0]  stage;
    logic [15:0] en;
    logic [3:0]  cond;
    logic        halted;
  } exp_t;

  exp_t sb[$];

  control_sequencer #(.INSTR_W(24), .WAIT_MAX(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .instr_in        (instr_in),
    .mem_ready       (mem_ready),
    .stall           (stall),
    .condition       (condition),
    .en_intermediate (en_intermediate),
    .stage           (stage),
    .halted          (halted),
    .mem_error       (mem_error)
`ifdef INSTR_COUNT_EN
    ,
    .instr_count     (instr_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(logic mr, logic st, logic [2:0] sg, logic [15:0] en,
                              logic [3:0] c, logic h);
    exp_t r;
    r.mr = mr; r.st = st; r.stage = sg; r.en = en; r.cond = c; r.halted = h;
    return r;
  endfunction

  task automatic drive(input exp_t e);
    sb.push_back(e);
    mem_ready = e.mr;
    stall     = e.st;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; mem_ready = 1'b0; stall = 1'b0; instr_in = '0;
    #2;
    checks++;
    if ({stage, en_intermediate, condition, halted, mem_error} !== {3'd0, 16'h0, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: stage=%0d en=%h cond=%h halted=%b mem_error=%b, want 0/0000/0/0/0",
               stage, en_intermediate, condition, halted, mem_error);
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (instr_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: instr_count=%0d want 0", instr_count);
    end
`endif
    @(negedge clock);
    checks++;
    if (en_intermediate !== 16'h0) begin
      errors++;
      $display("FAIL reset_held_en: en=%h want 0000", en_intermediate);
    end
    #1 reset = 1'b0;
    @(posedge clock); #1;
    e = mk(1'b0, 1'b0, 3'd0, 16'h0900, 4'h0, 1'b0);
    drive(e);
    @(negedge clock);
    e = sb.pop_front();
    checks++;
    if ({stage, en_intermediate, condition, halted} !== {e.stage, e.en, e.cond, e.halted}) begin
      errors++;
      $display("FAIL reset_release: stage=%0d en=%h cond=%h halted=%b, want stage=%0d en=%h cond=%h halted=%b",
               stage, en_intermediate, condition, halted, e.stage, e.en, e.cond, e.halted);
    end
  endtask

  task automatic test_alu();
    exp_t t[$];
    exp_t e;
    @(posedge clock); #1;
    instr_in = 24'h01_8000;
    t.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0905, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd1, 16'h0030, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd2, 16'h0440, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd4, 16'h0088, 4'h0, 1'b0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if ({stage, en_intermediate, condition, halted} !== {e.stage, e.en, e.cond, e.halted}) begin
        errors++;
        $display("FAIL alu[%0d]: stage=%0d en=%h cond=%h halted=%b, want stage=%0d en=%h cond=%h halted=%b",
                 i, stage, en_intermediate, condition, halted, e.stage, e.en, e.cond, e.halted);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_load_wait();
    exp_t t[$];
    exp_t e;
    instr_in = 24'h02_0000;
    t.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0905, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd1, 16'h0030, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd2, 16'h0840, 4'h0, 1'b0));
    for (int k = 0; k < 3; k++) t.push_back(mk(1'b0, 1'b0, 3'd3, 16'h0100, 4'h0, 1'b0));
    t.push_back(mk(1'b1, 1'b0, 3'd3, 16'h0180, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd4, 16'h0008, 4'h0, 1'b0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if ({stage, en_intermediate, condition, halted} !== {e.stage, e.en, e.cond, e.halted}) begin
        errors++;
        $display("FAIL load[%0d]: stage=%0d en=%h cond=%h halted=%b, want stage=%0d en=%h cond=%h halted=%b",
                 i, stage, en_intermediate, condition, halted, e.stage, e.en, e.cond, e.halted);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_branch_store();
    exp_t t[$];
    exp_t e;
    instr_in = 24'h14_0000;
    t.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0905, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd1, 16'h0030, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd2, 16'h0002, 4'h1, 1'b0));
    // store with cond=2, memory ready immediately
    t.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0905, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd1, 16'h0030, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd2, 16'h0840, 4'h2, 1'b0));
    t.push_back(mk(1'b1, 1'b0, 3'd3, 16'h0200, 4'h2, 1'b0));
    foreach (t[i]) begin
      if (i == 3) instr_in = 24'h23_0000;
      drive(t[i]);
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if ({stage, en_intermediate, condition, halted} !== {e.stage, e.en, e.cond, e.halted}) begin
        errors++;
        $display("FAIL branch_store[%0d]: stage=%0d en=%h cond=%h halted=%b, want stage=%0d en=%h cond=%h halted=%b",
                 i, stage, en_intermediate, condition, halted, e.stage, e.en, e.cond, e.halted);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_stall();
    exp_t t[$];
    exp_t e;
    instr_in = 24'h01_0000;
    t.push_back(mk(1'b1, 1'b1, 3'd0, 16'h0000, 4'h0, 1'b0));
    t.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0905, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd1, 16'h0030, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b1, 3'd2, 16'h0000, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b1, 3'd2, 16'h0000, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd2, 16'h0040, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd4, 16'h0088, 4'h0, 1'b0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if ({stage, en_intermediate, condition, halted} !== {e.stage, e.en, e.cond, e.halted}) begin
        errors++;
        $display("FAIL stall[%0d]: stage=%0d en=%h cond=%h halted=%b, want stage=%0d en=%h cond=%h halted=%b",
                 i, stage, en_intermediate, condition, halted, e.stage, e.en, e.cond, e.halted);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_timeout();
    exp_t t[$];
    exp_t e;
    for (int k = 0; k < 4; k++) t.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0900, 4'h0, 1'b0));
    for (int k = 0; k < 3; k++) t.push_back(mk(1'b1, 1'b0, 3'd5, 16'h0000, 4'h0, 1'b1));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if ({stage, en_intermediate, condition, halted} !== {e.stage, e.en, e.cond, e.halted}) begin
        errors++;
        $display("FAIL timeout[%0d]: stage=%0d en=%h cond=%h halted=%b, want stage=%0d en=%h cond=%h halted=%b",
                 i, stage, en_intermediate, condition, halted, e.stage, e.en, e.cond, e.halted);
      end
      @(posedge clock); #1;
    end
    checks++;
    if (mem_error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_mem_error: mem_error=%b want 1", mem_error);
    end
  endtask

  task automatic test_async_reset();
    exp_t t[$];
    exp_t e;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({stage, halted, mem_error} !== {3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_from_halt: stage=%0d halted=%b mem_error=%b, want 0/0/0", stage, halted, mem_error);
    end
    mem_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    instr_in = 24'h52_0000;
    t.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0905, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd1, 16'h0030, 4'h0, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd2, 16'h0840, 4'h5, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd3, 16'h0100, 4'h5, 1'b0));
    t.push_back(mk(1'b0, 1'b0, 3'd3, 16'h0100, 4'h5, 1'b0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if ({stage, en_intermediate, condition, halted} !== {e.stage, e.en, e.cond, e.halted}) begin
        errors++;
        $display("FAIL mid_mem[%0d]: stage=%0d en=%h cond=%h halted=%b, want stage=%0d en=%h cond=%h halted=%b",
                 i, stage, en_intermediate, condition, halted, e.stage, e.en, e.cond, e.halted);
      end
      @(posedge clock); #1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({stage, en_intermediate, condition, halted, mem_error} !== {3'd0, 16'h0, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_mid_mem: stage=%0d en=%h cond=%h halted=%b mem_error=%b, want 0/0000/0/0/0",
               stage, en_intermediate, condition, halted, mem_error);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({stage, en_intermediate} !== {3'd0, 16'h0900}) begin
      errors++;
      $display("FAIL after_release: stage=%0d en=%h, want 0/0900", stage, en_intermediate);
    end
  endtask

  task automatic test_nop_count();
    exp_t t[$];
    exp_t e;
`ifdef INSTR_COUNT_EN
    checks++;
    if (instr_count !== 32'd0) begin
      errors++;
      $display("FAIL count_after_reset: instr_count=%0d want 0", instr_count);
    end
`endif
    for (int k = 0; k < 4; k++) begin
      t.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0905, 4'h0, 1'b0));
      t.push_back(mk(1'b0, 1'b0, 3'd1, 16'h0030, 4'h0, 1'b0));
    end
    instr_in = 24'h00_0000;
    foreach (t[i]) begin
      // fourth instruction uses an unassigned opcode, which retires like a NOP
      if (i == 6) instr_in = 24'h09_0000;
      drive(t[i]);
      @(negedge clock);
      e = sb.pop_front();
      checks++;
      if ({stage, en_intermediate, condition, halted} !== {e.stage, e.en, e.cond, e.halted}) begin
        errors++;
        $display("FAIL nop[%0d]: stage=%0d en=%h cond=%h halted=%b, want stage=%0d en=%h cond=%h halted=%b",
                 i, stage, en_intermediate, condition, halted, e.stage, e.en, e.cond, e.halted);
      end
      @(posedge clock); #1;
`ifdef INSTR_COUNT_EN
      if (i == 5) begin
        checks++;
        if (instr_count !== 32'd3) begin
          errors++;
          $display("FAIL count_three_nops: instr_count=%0d want 3", instr_count);
        end
      end
`endif
    end
    checks++;
    if (stage !== 3'd0) begin
      errors++;
      $display("FAIL nop_return: stage=%0d want 0", stage);
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (instr_count !== 32'd4) begin
      errors++;
      $display("FAIL count_four: instr_count=%0d want 4", instr_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch_store();
    test_stall();
    test_timeout();
    test_async_reset();
    test_nop_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
